// File: rtl/sram_axi_bridge.sv
// Bridges the core's SRAM-like inst (read-only) and data (read/write) ports onto one AXI3 master.
// Optional: define SRAM_AXI_BRIDGE_RR_ARB_EN for round-robin AR arbitration instead of fixed data priority.
module sram_axi_bridge #(
   parameter logic [3:0] INST_ARID = 4'd0,
   parameter logic [3:0] DATA_ARID = 4'd1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic [70:0] data_cmd,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic [38:0] axi_ar,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   input  logic [35:0] axi_r,
   input  logic        axi_rvalid,
   output logic        axi_rready,
   output logic [34:0] axi_aw,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [35:0] axi_w,
   output logic        axi_wvalid,
   input  logic        axi_wready,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [1:0] {
      I_IDLE  = 2'd0,
      I_ISSUE = 2'd1,
      I_WAIT  = 2'd2
   } inst_state_t;

   typedef enum logic [2:0] {
      D_IDLE     = 3'd0,
      D_RD_ISSUE = 3'd1,
      D_RD_WAIT  = 3'd2,
      D_WR_ISSUE = 3'd3,
      D_WR_WAIT  = 3'd4
   } data_state_t;

   inst_state_t r_inst_state;
   inst_state_t w_inst_state_nxt;
   data_state_t r_data_state;
   data_state_t w_data_state_nxt;

   logic        r_inst_data_ok;
   logic [31:0] r_inst_rdata;
   logic        r_data_data_ok;
   logic [31:0] r_data_rdata;
   logic [38:0] r_axi_ar;
   logic        r_arvalid;
   logic [34:0] r_axi_aw;
   logic        r_awvalid;
   logic [35:0] r_axi_w;
   logic        r_wvalid;
   logic        r_rready;
   logic        r_bready;

   logic        w_cmd_wr;
   logic [1:0]  w_cmd_size;
   logic [31:0] w_cmd_addr;
   logic [3:0]  w_cmd_wstrb;
   logic [31:0] w_cmd_wdata;
   logic [3:0]  w_rid;
   logic [31:0] w_r_data;

   logic        w_ar_busy;
   logic        w_data_free;
   logic        w_inst_rd_cand;
   logic        w_data_rd_cand;
   logic        w_inst_rd_grant;
   logic        w_data_rd_grant;
   logic        w_data_wr_grant;
   logic        w_inst_r_hit;
   logic        w_data_r_hit;
   logic        w_data_b_hit;
   logic        w_aw_done;
   logic        w_w_done;

`ifdef SRAM_AXI_BRIDGE_RR_ARB_EN
   logic        r_last_data;
`endif

   assign w_cmd_wr    = data_cmd[70];
   assign w_cmd_size  = data_cmd[69:68];
   assign w_cmd_addr  = data_cmd[67:36];
   assign w_cmd_wstrb = data_cmd[35:32];
   assign w_cmd_wdata = data_cmd[31:0];
   assign w_rid       = axi_r[35:32];
   assign w_r_data    = axi_r[31:0];

   assign w_inst_r_hit = axi_rvalid && r_rready && (r_inst_state == I_WAIT) && (w_rid == INST_ARID);
   assign w_data_r_hit = axi_rvalid && r_rready && (r_data_state == D_RD_WAIT) && (w_rid == DATA_ARID);
   assign w_data_b_hit = axi_bvalid && r_bready && (r_data_state == D_WR_WAIT);
   assign w_aw_done    = !r_awvalid || axi_awready;
   assign w_w_done     = !r_wvalid || axi_wready;

   // Arbitration and addr_ok generation; a slot pulsing data_ok is not yet free to latch
   always_comb begin
      w_ar_busy       = (r_inst_state == I_ISSUE) || (r_data_state == D_RD_ISSUE);
      w_data_free     = (r_data_state == D_IDLE) && !r_data_data_ok && !reset;
      w_inst_rd_cand  = inst_req && (r_inst_state == I_IDLE) && !r_inst_data_ok && !w_ar_busy && !reset;
      w_data_rd_cand  = data_req && !w_cmd_wr && w_data_free && !w_ar_busy;
      w_data_wr_grant = data_req && w_cmd_wr && w_data_free;
`ifdef SRAM_AXI_BRIDGE_RR_ARB_EN
      if (w_inst_rd_cand && w_data_rd_cand) begin
         w_data_rd_grant = !r_last_data;
         w_inst_rd_grant = r_last_data;
      end else begin
         w_data_rd_grant = w_data_rd_cand;
         w_inst_rd_grant = w_inst_rd_cand;
      end
`else
      w_data_rd_grant = w_data_rd_cand;
      w_inst_rd_grant = w_inst_rd_cand && !w_data_rd_cand;
`endif
      inst_addr_ok = w_inst_rd_grant;
      data_addr_ok = w_data_rd_grant || w_data_wr_grant;
   end

   // Slot state registers
   always_ff @(posedge clock) begin
      if (reset) begin
         r_inst_state <= I_IDLE;
         r_data_state <= D_IDLE;
      end else begin
         r_inst_state <= w_inst_state_nxt;
         r_data_state <= w_data_state_nxt;
      end
   end

   // Inst slot next state
   always_comb begin
      w_inst_state_nxt = r_inst_state;
      case (r_inst_state)
         I_IDLE: begin
            if (w_inst_rd_grant) w_inst_state_nxt = I_ISSUE;
            else                 w_inst_state_nxt = I_IDLE;
         end
         I_ISSUE: begin
            if (axi_arready) w_inst_state_nxt = I_WAIT;
            else             w_inst_state_nxt = I_ISSUE;
         end
         I_WAIT: begin
            if (w_inst_r_hit) w_inst_state_nxt = I_IDLE;
            else              w_inst_state_nxt = I_WAIT;
         end
         default: w_inst_state_nxt = I_IDLE;
      endcase
   end

   // Data slot next state; a write leaves ISSUE only after both AW and W have handshaken
   always_comb begin
      w_data_state_nxt = r_data_state;
      case (r_data_state)
         D_IDLE: begin
            if (w_data_rd_grant)      w_data_state_nxt = D_RD_ISSUE;
            else if (w_data_wr_grant) w_data_state_nxt = D_WR_ISSUE;
            else                      w_data_state_nxt = D_IDLE;
         end
         D_RD_ISSUE: begin
            if (axi_arready) w_data_state_nxt = D_RD_WAIT;
            else             w_data_state_nxt = D_RD_ISSUE;
         end
         D_RD_WAIT: begin
            if (w_data_r_hit) w_data_state_nxt = D_IDLE;
            else              w_data_state_nxt = D_RD_WAIT;
         end
         D_WR_ISSUE: begin
            if (w_aw_done && w_w_done) w_data_state_nxt = D_WR_WAIT;
            else                       w_data_state_nxt = D_WR_ISSUE;
         end
         D_WR_WAIT: begin
            if (w_data_b_hit) w_data_state_nxt = D_IDLE;
            else              w_data_state_nxt = D_WR_WAIT;
         end
         default: w_data_state_nxt = D_IDLE;
      endcase
   end

   // AR channel: payload captured at grant and held until the handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         r_axi_ar  <= 39'd0;
         r_arvalid <= 1'b0;
      end else if (w_inst_rd_grant) begin
         r_axi_ar  <= {INST_ARID, inst_addr, 3'd2};
         r_arvalid <= 1'b1;
      end else if (w_data_rd_grant) begin
         r_axi_ar  <= {DATA_ARID, w_cmd_addr, {1'b0, w_cmd_size}};
         r_arvalid <= 1'b1;
      end else if (r_arvalid && axi_arready) begin
         r_arvalid <= 1'b0;
      end else begin
         r_arvalid <= r_arvalid;
      end
   end

   // AW and W channels: raised together, each dropped by its own handshake
   always_ff @(posedge clock) begin
      if (reset) begin
         r_axi_aw  <= 35'd0;
         r_axi_w   <= 36'd0;
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
      end else if (w_data_wr_grant) begin
         r_axi_aw  <= {w_cmd_addr, {1'b0, w_cmd_size}};
         r_axi_w   <= {w_cmd_wdata, w_cmd_wstrb};
         r_awvalid <= 1'b1;
         r_wvalid  <= 1'b1;
      end else begin
         if (r_awvalid && axi_awready) r_awvalid <= 1'b0;
         else                          r_awvalid <= r_awvalid;
         if (r_wvalid && axi_wready) r_wvalid <= 1'b0;
         else                        r_wvalid <= r_wvalid;
      end
   end

   // Response capture: data_ok and rdata are presented one cycle after the beat
   always_ff @(posedge clock) begin
      if (reset) begin
         r_inst_data_ok <= 1'b0;
         r_inst_rdata   <= 32'd0;
         r_data_data_ok <= 1'b0;
         r_data_rdata   <= 32'd0;
      end else begin
         r_inst_data_ok <= w_inst_r_hit;
         if (w_inst_r_hit) r_inst_rdata <= w_r_data;
         else              r_inst_rdata <= r_inst_rdata;
         r_data_data_ok <= w_data_r_hit || w_data_b_hit;
         if (w_data_r_hit) r_data_rdata <= w_r_data;
         else              r_data_rdata <= r_data_rdata;
      end
   end

   // R and B are always accepted once out of reset; beats for idle slots are dropped
   always_ff @(posedge clock) begin
      if (reset) begin
         r_rready <= 1'b0;
         r_bready <= 1'b0;
      end else begin
         r_rready <= 1'b1;
         r_bready <= 1'b1;
      end
   end

`ifdef SRAM_AXI_BRIDGE_RR_ARB_EN
   // Remembers which port took the last AR grant
   always_ff @(posedge clock) begin
      if (reset) begin
         r_last_data <= 1'b0;
      end else if (w_data_rd_grant) begin
         r_last_data <= 1'b1;
      end else if (w_inst_rd_grant) begin
         r_last_data <= 1'b0;
      end else begin
         r_last_data <= r_last_data;
      end
   end
`endif

   assign inst_data_ok = r_inst_data_ok;
   assign inst_rdata   = r_inst_rdata;
   assign data_data_ok = r_data_data_ok;
   assign data_rdata   = r_data_rdata;
   assign axi_ar       = r_axi_ar;
   assign axi_arvalid  = r_arvalid;
   assign axi_rready   = r_rready;
   assign axi_aw       = r_axi_aw;
   assign axi_awvalid  = r_awvalid;
   assign axi_w        = r_axi_w;
   assign axi_wvalid   = r_wvalid;
   assign axi_bready   = r_bready;

endmodule
